plot_sweeper: RTL and testbench
===============================

PLOT_SWEEPER -- requirements
Module: plot_sweeper

Interface
REQ-001 Parameter HOR_ACTIVE_PIXELS, default 640, meaning screen width and number of x columns swept.
REQ-002 Parameter VER_ACTIVE_PIXELS, default 480, meaning screen height; a y value >= this is off-screen.
REQ-003 Localparams XW = $clog2(HOR_ACTIVE_PIXELS) and YW = $clog2(VER_ACTIVE_PIXELS); the block shall derive all port widths from them.
REQ-004 Port clk, input, 1 bit, the single clock; every flop is on its rising edge.
REQ-005 Port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 Port start, input, 1 bit, a one-cycle request to plot one full frame.
REQ-007 Port busy, output, 1 bit, high from the cycle after start is accepted until done.
REQ-008 Port done, output, 1 bit, a one-cycle pulse when the frame is finished.
REQ-009 Port sm_start, output, 1 bit, evaluation request to the stack machine.
REQ-010 Port sm_ready, input, 1 bit, stack machine idle level.
REQ-011 Port sm_x, output, XW bits, column to evaluate.
REQ-012 Port sm_y, input, YW bits, evaluated screen row.
REQ-013 Port fb_we, output, 1 bit, framebuffer pixel write request.
REQ-014 Port fb_x, output, XW bits, pixel column.
REQ-015 Port fb_y, output, YW bits, pixel row.
REQ-016 Port fb_ready, input, 1 bit; a write is accepted on any cycle where fb_we and fb_ready are both high.

Function
REQ-017 The FSM shall have the states IDLE, REQ, SKIP, WAIT, DRAW, NEXT, FIN.
REQ-018 IDLE transitions:
- start high: x <= 0, has_prev <= 0, go to REQ.
- start while not IDLE: ignored.
REQ-019 REQ: when sm_ready is high, assert sm_start for exactly one cycle with sm_x = x, then go to SKIP; otherwise stay in REQ.
REQ-020 SKIP: sm_ready is ignored for one cycle, because ready falls one cycle after start; then go to WAIT.
REQ-021 WAIT: on the first cycle with sm_ready high, latch cur_y <= sm_y and go to DRAW.
REQ-022 Segment setup on entering DRAW:
- cur on-screen and has_prev: lo = min(prev_y, cur_y), hi = max(prev_y, cur_y).
- cur on-screen and not has_prev: lo = hi = cur_y.
- cur off-screen: no pixels.
REQ-023 DRAW: emit fb_we with fb_x = x and fb_y = lo..hi in ascending order, one row per accepted write.
- fb_x and fb_y shall hold stable while fb_we is high and fb_ready is low.
- After the write of hi is accepted (or immediately if there are no pixels), go to NEXT.
REQ-024 NEXT bookkeeping:
- prev_y <= cur_y; has_prev <= (cur_y < VER_ACTIVE_PIXELS).
- If x == HOR_ACTIVE_PIXELS-1, go to FIN; else x <= x+1 and go to REQ.
REQ-025 FIN: pulse done for one cycle and go to IDLE; busy is low in IDLE.
REQ-026 Pixel count per column is hi-lo+1, at most VER_ACTIVE_PIXELS; the row counter shall be YW bits wide with no wrap past hi.
REQ-027 Comparisons shall be unsigned; x shall never exceed HOR_ACTIVE_PIXELS-1.
REQ-028 sm_x shall stay stable from REQ until WAIT exits.

Reset
REQ-029 While rst_n is low, the block shall hold these values:
- state IDLE.
- busy, done, sm_start, fb_we = 0.
- sm_x, fb_x, fb_y, x, prev_y, cur_y = 0; has_prev = 0.
REQ-030 If rst_n is asserted mid-frame (including mid-segment), the block shall abort immediately without emitting any further writes; after release it waits in IDLE for a new start.

Structure
REQ-031 The FSM state enum and the YW/XW width helpers shall live in the shared package plot_pkg.
REQ-032 The block shall use one sub-module, segment_emitter (lo/hi row counter with fb_ready backpressure); everything else is inline.

Verification
REQ-033 With a stub machine returning y = 240 constantly and fb_ready = 1: expect 640 writes, one per x at fb_y = 240, and exactly one done pulse.
REQ-034 With y(0) = 100 and y(1) = 104: column 1 writes rows 100,101,102,103,104 in order; column 0 writes only row 100.
REQ-035 With y(5) = 480 (off-screen) and y(6) = 50: column 5 has no writes and column 6 writes only row 50.
REQ-036 With fb_ready toggled pseudo-randomly: the write sequence is identical to the fb_ready = 1 run, and fb_x/fb_y are held while stalled.
REQ-037 With a stub ready that drops one cycle after start and returns after 20 cycles: exactly one sm_start per column, and sm_y is sampled only after ready returns.
REQ-038 With rst_n pulsed low during column 300's segment: fb_we falls immediately, all outputs reach reset values, and a new start replots from x = 0.

Source files
------------

// File: rtl/plot_pkg.sv
// rtl/plot_pkg.sv - shared FSM state type and width helper for the plot sweeper
package plot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        SKIP,
        WAIT,
        DRAW,
        NEXT,
        FIN
    } state_e;

    // Bits needed to index n items; never narrower than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/segment_emitter.sv
// rtl/segment_emitter.sv - walks one column segment lo..hi as framebuffer writes with fb_ready backpressure
module segment_emitter #(
    parameter int XW = 10,
    parameter int YW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [YW-1:0] lo,
    input  logic [YW-1:0] hi,
    input  logic [XW-1:0] col,
    input  logic          fb_ready,
    output logic          fb_we,
    output logic [XW-1:0] fb_x,
    output logic [YW-1:0] fb_y
);

    logic          active_q, active_d;
    logic [YW-1:0] row_q, row_d;
    logic [YW-1:0] hi_q, hi_d;
    logic [XW-1:0] col_q, col_d;

    always_comb begin
        active_d = active_q;
        row_d    = row_q;
        hi_d     = hi_q;
        col_d    = col_q;
        if (load) begin
            active_d = 1'b1;
            row_d    = lo;
            hi_d     = hi;
            col_d    = col;
        end else if (active_q && fb_ready) begin
            // Stop on hi rather than counting past it so the row never wraps.
            if (row_q == hi_q) begin
                active_d = 1'b0;
            end else begin
                row_d = row_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            row_q    <= '0;
            hi_q     <= '0;
            col_q    <= '0;
        end else begin
            active_q <= active_d;
            row_q    <= row_d;
            hi_q     <= hi_d;
            col_q    <= col_d;
        end
    end

    assign fb_we = active_q;
    assign fb_x  = col_q;
    assign fb_y  = row_q;

endmodule

// File: rtl/plot_sweeper.sv
// rtl/plot_sweeper.sv - sweeps every column through the stack machine and draws connected vertical segments
module plot_sweeper
    import plot_pkg::*;
#(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480,
    localparam int XW = width_of(HOR_ACTIVE_PIXELS),
    localparam int YW = width_of(VER_ACTIVE_PIXELS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          sm_start,
    input  logic          sm_ready,
    output logic [XW-1:0] sm_x,
    input  logic [YW-1:0] sm_y,
    output logic          fb_we,
    output logic [XW-1:0] fb_x,
    output logic [YW-1:0] fb_y,
    input  logic          fb_ready
);

    localparam logic [XW-1:0] X_LAST = XW'(HOR_ACTIVE_PIXELS - 1);
    localparam logic [YW:0]   Y_LIM  = (YW+1)'(VER_ACTIVE_PIXELS);

    state_e        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] prev_y_q, prev_y_d;
    logic [YW-1:0] cur_y_q, cur_y_d;
    logic          has_prev_q, has_prev_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          sm_start_q, sm_start_d;

    logic          seg_load;
    logic [YW-1:0] seg_lo, seg_hi;
    logic          cur_on;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        prev_y_d   = prev_y_q;
        cur_y_d    = cur_y_q;
        has_prev_d = has_prev_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sm_start_d = 1'b0;
        seg_load   = 1'b0;

        // Segment bounds are formed straight from sm_y so the emitter loads as DRAW is entered.
        cur_on = {1'b0, sm_y} < Y_LIM;
        seg_lo = sm_y;
        seg_hi = sm_y;
        if (has_prev_q) begin
            seg_lo = (prev_y_q < sm_y) ? prev_y_q : sm_y;
            seg_hi = (prev_y_q < sm_y) ? sm_y : prev_y_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d        = '0;
                    has_prev_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (sm_ready) begin
                    sm_start_d = 1'b1;
                    state_d    = SKIP;
                end
            end
            SKIP: state_d = WAIT;
            WAIT: begin
                if (sm_ready) begin
                    cur_y_d  = sm_y;
                    seg_load = cur_on;
                    state_d  = DRAW;
                end
            end
            DRAW: begin
                if (!fb_we) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                prev_y_d   = cur_y_q;
                has_prev_d = {1'b0, cur_y_q} < Y_LIM;
                if (x_q == X_LAST) begin
                    state_d = FIN;
                end else begin
                    x_d     = x_q + 1'b1;
                    state_d = REQ;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            x_q        <= '0;
            prev_y_q   <= '0;
            cur_y_q    <= '0;
            has_prev_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sm_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            prev_y_q   <= prev_y_d;
            cur_y_q    <= cur_y_d;
            has_prev_q <= has_prev_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sm_start_q <= sm_start_d;
        end
    end

    segment_emitter #(
        .XW(XW),
        .YW(YW)
    ) u_segment_emitter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (seg_load),
        .lo       (seg_lo),
        .hi       (seg_hi),
        .col      (x_q),
        .fb_ready (fb_ready),
        .fb_we    (fb_we),
        .fb_x     (fb_x),
        .fb_y     (fb_y)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign sm_start = sm_start_q;
    assign sm_x     = x_q;

endmodule

// File: tb/tb_plot_sweeper.sv
// tb/tb_plot_sweeper.sv - self-checking bench for plot_sweeper against a column-by-column segment model
module tb_plot_sweeper;

    localparam int H  = 640;
    localparam int V  = 480;
    localparam int XW = 10;
    localparam int YW = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, sm_start, fb_we;
    logic          sm_ready;
    logic          fb_ready = 1'b1;
    logic [XW-1:0] sm_x, fb_x;
    logic [YW-1:0] sm_y, fb_y;

    plot_sweeper #(
        .HOR_ACTIVE_PIXELS(H),
        .VER_ACTIVE_PIXELS(V)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .sm_start (sm_start),
        .sm_ready (sm_ready),
        .sm_x     (sm_x),
        .sm_y     (sm_y),
        .fb_we    (fb_we),
        .fb_x     (fb_x),
        .fb_y     (fb_y),
        .fb_ready (fb_ready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int ytab[H];
    int lat_cfg = 1;
    bit rand_ready = 1'b0;

    // Stack machine stub: ready drops the cycle after sm_start, returns after lat_cfg cycles.
    int            stub_cnt;
    logic [XW-1:0] stub_x;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sm_ready <= 1'b1;
            stub_cnt <= 0;
            stub_x   <= '0;
            sm_y     <= '0;
        end else if (sm_ready) begin
            if (sm_start) begin
                sm_ready <= 1'b0;
                stub_cnt <= lat_cfg;
                stub_x   <= sm_x;
            end
        end else if (stub_cnt <= 1) begin
            sm_ready <= 1'b1;
            sm_y     <= YW'(ytab[stub_x]);
        end else begin
            stub_cnt <= stub_cnt - 1;
            sm_y     <= YW'($urandom_range(0, V - 1));
        end
    end

    always @(posedge clk) fb_ready <= rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;

    int            cap[$];
    int            done_cnt;
    int            hold_bad;
    int            starts_col[H];
    bit            stalled;
    bit            clr_mon = 1'b0;
    logic [XW-1:0] hx;
    logic [YW-1:0] hy;
    always @(negedge clk) begin
        if (clr_mon) begin
            cap.delete();
            done_cnt = 0;
            hold_bad = 0;
            stalled  = 1'b0;
            foreach (starts_col[i]) starts_col[i] = 0;
        end else begin
            if (stalled && !(fb_we && fb_x == hx && fb_y == hy)) hold_bad++;
            if (sm_start) starts_col[sm_x]++;
            if (done) done_cnt++;
            if (fb_we && fb_ready) cap.push_back(int'(fb_x) * 65536 + int'(fb_y));
            stalled = fb_we && !fb_ready;
            hx = fb_x;
            hy = fb_y;
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: each on-screen column draws from the previous on-screen y to its own y.
    function automatic void model(output int q[$]);
        int prev, lo, hi;
        bit has;
        q = {};
        has = 1'b0;
        prev = 0;
        for (int x = 0; x < H; x++) begin
            if (ytab[x] < V) begin
                lo = has ? ((prev < ytab[x]) ? prev : ytab[x]) : ytab[x];
                hi = has ? ((prev > ytab[x]) ? prev : ytab[x]) : ytab[x];
                for (int y = lo; y <= hi; y++) q.push_back(x * 65536 + y);
            end
            has = ytab[x] < V;
            prev = ytab[x];
        end
    endfunction

    function automatic void fill(input int pat);
        int y;
        for (int x = 0; x < H; x++) begin
            case (pat)
                0:       ytab[x] = 240;
                1:       ytab[x] = (x == 0) ? 100 : 104;
                2:       ytab[x] = (x == 5) ? 480 : 50;
                5:       ytab[x] = (x == 300) ? 20 : 240;
                default: ytab[x] = 0;
            endcase
        end
        if (pat == 3) begin
            y = int'($urandom_range(100, 380));
            for (int x = 0; x < H; x++) begin
                if ($urandom_range(0, 63) == 0) begin
                    ytab[x] = 480 + int'($urandom_range(0, 31));
                end else begin
                    y = y + int'($urandom_range(0, 6)) - 3;
                    if (y < 0) y = 0;
                    if (y > V - 1) y = V - 1;
                    ytab[x] = y;
                end
            end
        end
    endfunction

    task automatic col_rows(input int x, output int r[$]);
        r = {};
        foreach (cap[i]) if ((cap[i] >> 16) == x) r.push_back(cap[i] & 'hFFFF);
    endtask

    task automatic run_frame(input int budget, input bit extra, output bit ok);
        int n;
        clr_mon = 1'b1;
        @(negedge clk);
        #1 clr_mon = 1'b0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (!done && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            start = extra && (n == 500);
        end
        ok = done;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic compare_frame(input string nm);
        int exp_q[$];
        int first, bad;
        model(exp_q);
        check({nm, " write count"}, cap.size(), exp_q.size());
        first = -1;
        for (int i = 0; i < cap.size() && i < exp_q.size(); i++) begin
            if (cap[i] != exp_q[i]) begin
                first = i;
                break;
            end
        end
        check({nm, " first sequence diff index"}, first, -1);
        check({nm, " done pulses"}, done_cnt, 1);
        bad = 0;
        foreach (starts_col[i]) if (starts_col[i] != 1) bad++;
        check({nm, " columns without exactly one sm_start"}, bad, 0);
        check({nm, " stall hold violations"}, hold_bad, 0);
        check({nm, " busy after done"}, int'(busy), 0);
    endtask

    typedef struct {
        int pat;
        int lat;
        bit rnd;
        int exp_writes;
    } vec_t;

    initial begin
        vec_t vt[5];
        int   rows[$];
        int   saved[$];
        int   n, bad;
        bit   ok;

        vt[0] = '{pat: 0, lat: 1,  rnd: 1'b0, exp_writes: 640};
        vt[1] = '{pat: 1, lat: 2,  rnd: 1'b0, exp_writes: 644};
        vt[2] = '{pat: 2, lat: 1,  rnd: 1'b0, exp_writes: 639};
        vt[3] = '{pat: 3, lat: 2,  rnd: 1'b0, exp_writes: -1};
        vt[4] = '{pat: 4, lat: 20, rnd: 1'b1, exp_writes: -1};

        repeat (3) @(posedge clk);
        #1;
        check("reset ctl {busy,done,sm_start,fb_we}", int'({busy, done, sm_start, fb_we}), 0);
        check("reset sm_x", int'(sm_x), 0);
        check("reset fb_x", int'(fb_x), 0);
        check("reset fb_y", int'(fb_y), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int t = 0; t < 5; t++) begin
            if (vt[t].pat != 4) fill(vt[t].pat);
            lat_cfg = vt[t].lat;
            rand_ready = vt[t].rnd;
            run_frame(60000, t == 0, ok);
            check($sformatf("vec%0d frame finished", t), int'(ok), 1);
            compare_frame($sformatf("vec%0d", t));
            if (vt[t].exp_writes >= 0)
                check($sformatf("vec%0d table write count", t), cap.size(), vt[t].exp_writes);
            if (vt[t].pat == 0) begin
                bad = 0;
                foreach (cap[i]) if ((cap[i] & 'hFFFF) != 240 || (cap[i] >> 16) != i) bad++;
                check("const240 writes off x or row", bad, 0);
            end
            if (vt[t].pat == 1) begin
                col_rows(0, rows);
                check("col0 row count", rows.size(), 1);
                check("col0 row", (rows.size() > 0) ? rows[0] : -1, 100);
                col_rows(1, rows);
                check("col1 row count", rows.size(), 5);
                for (int i = 0; i < rows.size(); i++) check($sformatf("col1 row %0d", i), rows[i], 100 + i);
            end
            if (vt[t].pat == 2) begin
                col_rows(5, rows);
                check("offscreen col5 row count", rows.size(), 0);
                col_rows(6, rows);
                check("col6 row count", rows.size(), 1);
                check("col6 row", (rows.size() > 0) ? rows[0] : -1, 50);
            end
            if (vt[t].pat == 3) saved = cap;
            if (vt[t].pat == 4) begin
                check("stalled run length vs unstalled", cap.size(), saved.size());
                bad = 0;
                for (int i = 0; i < cap.size() && i < saved.size(); i++) if (cap[i] != saved[i]) bad++;
                check("stalled run entries differing", bad, 0);
            end
        end

        fill(5);
        lat_cfg = 1;
        rand_ready = 1'b0;
        clr_mon = 1'b1;
        @(negedge clk);
        #1 clr_mon = 1'b0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (!(fb_we && fb_x == 300 && fb_y == 30) && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reached column 300 segment", int'(fb_we && fb_x == 300 && fb_y == 30), 1);
        #2 rst_n = 1'b0;
        #1;
        check("fb_we at mid-segment reset", int'(fb_we), 0);
        check("ctl at mid-segment reset", int'({busy, done, sm_start}), 0);
        check("x outputs at mid-segment reset", int'(sm_x) + int'(fb_x), 0);
        check("fb_y at mid-segment reset", int'(fb_y), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        clr_mon = 1'b1;
        @(negedge clk);
        #1 clr_mon = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("writes after reset release", cap.size(), 0);
        check("busy after reset release", int'(busy), 0);
        run_frame(60000, 1'b0, ok);
        check("replot frame finished", int'(ok), 1);
        compare_frame("replot");
        check("replot first x", (cap.size() > 0) ? (cap[0] >> 16) : -1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
